// File: rtl/gate_seq_pkg.sv
// Shared constants and table record layout for the gate test-vector sequencer.
package gate_seq_pkg;

  localparam int GATE_IN_W   = 4;
  localparam int GATE_OUT_W  = 10;
  // Storage width of the dwell field in a table record; DWELL_W of the
  // controller must not exceed this.
  localparam int DWELL_MAX_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef struct packed {
    logic [GATE_IN_W-1:0]   vec;
    logic [GATE_OUT_W-1:0]  exp;
    logic [DWELL_MAX_W-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/gate_seq_ctrl_if.sv
// Host/configuration and gate-datapath signals of the sequencer.
interface gate_seq_ctrl_if
  import gate_seq_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int DWELL_W = 4
);

  localparam int IDX_W = $clog2(NUM_VEC);
  localparam int CNT_W = $clog2(NUM_VEC + 1);

  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_addr;
  logic [GATE_IN_W-1:0]  cfg_vec;
  logic [GATE_OUT_W-1:0] cfg_exp;
  logic [DWELL_W-1:0]    cfg_dwell;
  logic [IDX_W:0]        cfg_len;
  logic                  start;
  logic                  abort;
  logic [GATE_OUT_W-1:0] gate_o;
  logic                  gate_a;
  logic                  gate_b;
  logic                  gate_c;
  logic                  gate_d;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      pass_cnt;
  logic [CNT_W-1:0]      fail_cnt;
  logic [IDX_W-1:0]      first_fail;
  logic                  fail_seen;

  modport slave (
    input  cfg_we, cfg_addr, cfg_vec, cfg_exp, cfg_dwell, cfg_len, start, abort, gate_o,
    output gate_a, gate_b, gate_c, gate_d, busy, done, pass_cnt, fail_cnt, first_fail, fail_seen
  );

  modport master (
    output cfg_we, cfg_addr, cfg_vec, cfg_exp, cfg_dwell, cfg_len, start, abort, gate_o,
    input  gate_a, gate_b, gate_c, gate_d, busy, done, pass_cnt, fail_cnt, first_fail, fail_seen
  );

endinterface

// File: rtl/gate_vec_table.sv
// Vector table: one synchronous write port, one asynchronous read port,
// whole array cleared by the asynchronous reset.
module gate_vec_table
  import gate_seq_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int IDX_W   = $clog2(NUM_VEC)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  entry_t           wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output entry_t           rd_data
);

  localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(NUM_VEC);

  entry_t mem [NUM_VEC];

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH);

  // Store one record per write strobe; reset wipes every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        mem[i] <= '0;
      end
    end else if (we && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Out-of-range reads return an empty record.
  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/gate_seq_ctrl.sv
// Gate test-vector sequencer: drives table vectors onto the datapath for their
// dwell time, compares the datapath outputs on the last dwell cycle and keeps
// pass/fail statistics for the run.
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int DWELL_W = 4
) (
  input logic           clk,
  input logic           reset_n,
  gate_seq_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_VEC);
  localparam int CNT_W = $clog2(NUM_VEC + 1);
  localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(NUM_VEC);

  logic [1:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W:0]        len;
  logic [DWELL_W-1:0]    dwell_cnt;
  logic [GATE_IN_W-1:0]  gate_vec;
  logic [GATE_OUT_W-1:0] cur_exp;
  logic [CNT_W-1:0]      pass_cnt;
  logic [CNT_W-1:0]      fail_cnt;
  logic [IDX_W-1:0]      first_fail;
  logic                  fail_seen;

  logic [IDX_W:0]        len_clamp;
  logic [IDX_W-1:0]      rd_addr;
  entry_t                rd_entry;
  entry_t                wr_entry;
  logic [DWELL_W-1:0]    dwell_load;
  logic                  last_vec;
  logic                  match;
  logic                  table_we;

  // The table only accepts writes while idle; the read port always points at
  // the record that will be loaded next (entry 0 at start, idx+1 while running).
  assign table_we = bus.cfg_we && (state == ST_IDLE);
  assign wr_entry = '{vec: bus.cfg_vec, exp: bus.cfg_exp, dwell: DWELL_MAX_W'(bus.cfg_dwell)};
  assign rd_addr  = (state == ST_RUN) ? idx + 1'b1 : '0;

  gate_vec_table #(
    .NUM_VEC (NUM_VEC),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (table_we),
    .wr_addr (bus.cfg_addr),
    .wr_data (wr_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  // Run length is capped at the table depth; a zero dwell still holds one cycle.
  always_comb begin
    len_clamp  = (bus.cfg_len > DEPTH) ? DEPTH : bus.cfg_len;
    dwell_load = (rd_entry.dwell == '0) ? DWELL_W'(1) : DWELL_W'(rd_entry.dwell);
    last_vec   = ({1'b0, idx} == (len - 1'b1));
    match      = (bus.gate_o == cur_exp);
  end

  // Sequencer FSM with dwell countdown and pass/fail scoreboard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      len        <= '0;
      dwell_cnt  <= '0;
      gate_vec   <= '0;
      cur_exp    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gate_vec <= '0;
          if (bus.start) begin
            len        <= len_clamp;
            idx        <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            if (len_clamp == '0) begin
              state <= ST_FIN;
            end else begin
              state     <= ST_RUN;
              dwell_cnt <= dwell_load;
              gate_vec  <= rd_entry.vec;
              cur_exp   <= rd_entry.exp;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state    <= ST_IDLE;
            gate_vec <= '0;
          end else if (dwell_cnt == DWELL_W'(1)) begin
            if (match) begin
              pass_cnt <= pass_cnt + 1'b1;
            end else begin
              fail_cnt <= fail_cnt + 1'b1;
              if (!fail_seen) begin
                first_fail <= idx;
                fail_seen  <= 1'b1;
              end
            end
            if (last_vec) begin
              state    <= ST_FIN;
              gate_vec <= '0;
            end else begin
              idx       <= idx + 1'b1;
              dwell_cnt <= dwell_load;
              gate_vec  <= rd_entry.vec;
              cur_exp   <= rd_entry.exp;
            end
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        ST_FIN: begin
          state    <= ST_IDLE;
          gate_vec <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          gate_vec <= '0;
        end
      endcase
    end
  end

  assign bus.gate_a     = gate_vec[3];
  assign bus.gate_b     = gate_vec[2];
  assign bus.gate_c     = gate_vec[1];
  assign bus.gate_d     = gate_vec[0];
  assign bus.busy       = (state == ST_RUN);
  assign bus.done       = (state == ST_FIN);
  assign bus.pass_cnt   = pass_cnt;
  assign bus.fail_cnt   = fail_cnt;
  assign bus.first_fail = first_fail;
  assign bus.fail_seen  = fail_seen;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Self-checking bench for gate_seq_ctrl: behavioural gate datapath model,
// shadow vector table, directed table rows and randomized runs.
module tb_gate_seq_ctrl;

  localparam int NUM_VEC = 8;
  localparam int DWELL_W = 4;
  localparam int IDX_W   = $clog2(NUM_VEC);
  localparam logic [9:0] O3_MASK = 10'h080;

  typedef struct {
    int          len;
    logic [15:0] cmask;
    int          pass;
    int          fail;
    int          ff;
    bit          seen;
    int          lat;
  } row_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] cmask;
  logic [3:0]  pins;

  logic [3:0]  sh_vec   [NUM_VEC];
  logic [9:0]  sh_exp   [NUM_VEC];
  logic [3:0]  sh_dwell [NUM_VEC];

  int total = 0;
  int bad   = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  gate_seq_ctrl_if #(.NUM_VEC(NUM_VEC), .DWELL_W(DWELL_W)) bus ();

  gate_seq_ctrl #(.NUM_VEC(NUM_VEC), .DWELL_W(DWELL_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [9:0] gate_fn(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {a & b, a | b, a ^ b, a & c, c | d, b ^ d, a & ~d, a & b & c & d, a | b | c | d, ^v};
  endfunction

  assign pins        = {bus.gate_a, bus.gate_b, bus.gate_c, bus.gate_d};
  assign bus.gate_o  = gate_fn(pins) ^ (cmask[pins] ? O3_MASK : 10'h000);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, need %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [IDX_W-1:0] addr, input logic [3:0] vec,
                               input logic [9:0] ex, input logic [DWELL_W-1:0] dwell,
                               input logic [IDX_W:0] len, input logic start, input logic abort);
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_vec   = vec;
    bus.cfg_exp   = ex;
    bus.cfg_dwell = dwell;
    bus.cfg_len   = len;
    bus.start     = start;
    bus.abort     = abort;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
  endtask

  task automatic writeEntry(input int addr, input logic [3:0] vec, input logic [9:0] ex, input logic [3:0] dwell);
    applyStimulus(1'b1, IDX_W'(addr), vec, ex, dwell, '0, 1'b0, 1'b0);
    sh_vec[addr]   = vec;
    sh_exp[addr]   = ex;
    sh_dwell[addr] = dwell;
  endtask

  // Starts a run and follows it to completion. Pin trace and results come from
  // the shadow table unless a directed row supplies the expected results.
  task automatic runAndCheck(input string tag, input int len, input bit use_row,
                             input int r_pass, input int r_fail, input int r_ff, input bit r_seen, input int r_lat,
                             input bit wr, input int waddr, input logic [3:0] wvec, input logic [9:0] wexp,
                             input logic [3:0] wdwell);
    logic [3:0] trace [$];
    logic [9:0] out;
    int eff, d, m_pass, m_fail, m_ff, m_lat, done_cyc;
    bit m_seen;
    m_pass = 0; m_fail = 0; m_ff = 0; m_seen = 0;
    eff = (len > NUM_VEC) ? NUM_VEC : len;
    for (int k = 0; k < eff; k++) begin
      d = (sh_dwell[k] == 4'd0) ? 1 : int'(sh_dwell[k]);
      for (int j = 0; j < d; j++) trace.push_back(sh_vec[k]);
      out = gate_fn(sh_vec[k]) ^ (cmask[sh_vec[k]] ? O3_MASK : 10'h000);
      if (out == sh_exp[k]) m_pass++;
      else begin
        if (!m_seen) m_ff = k;
        m_seen = 1;
        m_fail++;
      end
    end
    m_lat = trace.size() + 1;
    if (use_row) begin
      m_pass = r_pass; m_fail = r_fail; m_ff = r_ff; m_seen = r_seen; m_lat = r_lat;
    end

    applyStimulus(wr, IDX_W'(waddr), wvec, wexp, wdwell, (IDX_W + 1)'(len), 1'b1, 1'b0);
    if (wr) begin
      sh_vec[waddr] = wvec; sh_exp[waddr] = wexp; sh_dwell[waddr] = wdwell;
    end

    done_cyc = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cyc <= trace.size()) begin
        checkOutput($sformatf("%s pins@%0d", tag, cyc), 32'(pins), 32'(trace[cyc-1]));
        checkOutput($sformatf("%s busy@%0d", tag, cyc), 32'(bus.busy), 32'd1);
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s done_latency", tag), done_cyc, m_lat);
    checkOutput($sformatf("%s pins_at_done", tag), 32'(pins), 32'd0);
    checkOutput($sformatf("%s busy_at_done", tag), 32'(bus.busy), 32'd0);
    checkOutput($sformatf("%s pass_cnt", tag), 32'(bus.pass_cnt), m_pass);
    checkOutput($sformatf("%s fail_cnt", tag), 32'(bus.fail_cnt), m_fail);
    checkOutput($sformatf("%s first_fail", tag), 32'(bus.first_fail), m_ff);
    checkOutput($sformatf("%s fail_seen", tag), 32'(bus.fail_seen), 32'(m_seen));
    @(negedge clk);
    checkOutput($sformatf("%s done_one_cycle", tag), 32'(bus.done), 32'd0);
    checkOutput($sformatf("%s pass_hold", tag), 32'(bus.pass_cnt), m_pass);
  endtask

  // Stops a runaway simulation.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    row_t rows [6];
    logic [3:0] v;
    logic [9:0] ex;

    rows[0] = '{len: 3, cmask: 16'h0000, pass: 3, fail: 0, ff: 0, seen: 1'b0, lat: 5};
    rows[1] = '{len: 3, cmask: 16'h0020, pass: 2, fail: 1, ff: 1, seen: 1'b1, lat: 5};
    rows[2] = '{len: 2, cmask: 16'h0400, pass: 1, fail: 1, ff: 0, seen: 1'b1, lat: 4};
    rows[3] = '{len: 3, cmask: 16'h0024, pass: 1, fail: 2, ff: 1, seen: 1'b1, lat: 5};
    rows[4] = '{len: 1, cmask: 16'h0000, pass: 1, fail: 0, ff: 0, seen: 1'b0, lat: 2};
    rows[5] = '{len: 0, cmask: 16'h0000, pass: 0, fail: 0, ff: 0, seen: 1'b0, lat: 1};

    reset_n = 1'b0;
    cmask   = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_vec = '0; bus.cfg_exp = '0;
    bus.cfg_dwell = '0; bus.cfg_len = '0; bus.start = 1'b0; bus.abort = 1'b0;
    for (int i = 0; i < NUM_VEC; i++) begin
      sh_vec[i] = '0; sh_exp[i] = '0; sh_dwell[i] = '0;
    end

    #12;
    checkOutput("reset pins", 32'(pins), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset pass_cnt", 32'(bus.pass_cnt), 32'd0);
    checkOutput("reset fail_cnt", 32'(bus.fail_cnt), 32'd0);
    checkOutput("reset first_fail", 32'(bus.first_fail), 32'd0);
    checkOutput("reset fail_seen", 32'(bus.fail_seen), 32'd0);
    #5 reset_n = 1'b1;
    @(negedge clk);

    // Directed table rows over the three-entry table.
    writeEntry(0, 4'b1010, gate_fn(4'b1010), 4'd1);
    writeEntry(1, 4'b0101, gate_fn(4'b0101), 4'd2);
    writeEntry(2, 4'b0010, gate_fn(4'b0010), 4'd1);
    for (int r = 0; r < 6; r++) begin
      cmask = rows[r].cmask;
      runAndCheck($sformatf("row%0d", r), rows[r].len, 1'b1, rows[r].pass, rows[r].fail,
                  rows[r].ff, rows[r].seen, rows[r].lat, 1'b0, 0, 4'd0, 10'd0, 4'd0);
    end
    cmask = '0;

    // Start during FIN is ignored.
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("fin done", 32'(bus.done), 32'd1);
    applyStimulus(1'b0, '0, '0, '0, '0, 4'd3, 1'b1, 1'b0);
    checkOutput("fin_start busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("fin_start busy2", 32'(bus.busy), 32'd0);

    // Write and start together: run sees the old entry, rerun sees the new one.
    runAndCheck("wr_start", 1, 1'b1, 1, 0, 0, 1'b0, 2, 1'b1, 0, 4'b0110, gate_fn(4'b0110), 4'd3);
    runAndCheck("wr_after", 1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 4'd0, 10'd0, 4'd0);

    // Zero dwell is held for one cycle.
    writeEntry(0, 4'b1010, gate_fn(4'b1010), 4'd0);
    runAndCheck("dwell0", 1, 1'b1, 1, 0, 0, 1'b0, 2, 1'b0, 0, 4'd0, 10'd0, 4'd0);

    // Abort mid-dwell; start and table write during the run are ignored.
    writeEntry(0, 4'b1100, gate_fn(4'b1100), 4'd4);
    applyStimulus(1'b0, '0, '0, '0, '0, 4'd1, 1'b1, 1'b0);
    checkOutput("abort c1 pins", 32'(pins), 32'b1100);
    applyStimulus(1'b1, '0, 4'b0011, gate_fn(4'b0011), 4'd1, 4'd2, 1'b1, 1'b0);
    checkOutput("abort c2 busy", 32'(bus.busy), 32'd1);
    checkOutput("abort c2 pins", 32'(pins), 32'b1100);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort pins", 32'(pins), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort pass_cnt", 32'(bus.pass_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort no_done%0d", i), 32'(bus.done), 32'd0);
    end
    runAndCheck("abort_rerun", 1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 4'd0, 10'd0, 4'd0);

    // Abort on the compare cycle wins over the count.
    writeEntry(0, 4'b1100, gate_fn(4'b1100), 4'd1);
    applyStimulus(1'b0, '0, '0, '0, '0, 4'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("abort_cmp pass_cnt", 32'(bus.pass_cnt), 32'd0);
    checkOutput("abort_cmp fail_cnt", 32'(bus.fail_cnt), 32'd0);
    checkOutput("abort_cmp busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("abort_cmp done", 32'(bus.done), 32'd0);

    // Length above the table depth runs every entry.
    for (int a = 0; a < NUM_VEC; a++) begin
      v = 4'(a + 3);
      writeEntry(a, v, gate_fn(v), 4'd1);
    end
    runAndCheck("len12", 12, 1'b1, 8, 0, 0, 1'b0, 9, 1'b0, 0, 4'd0, 10'd0, 4'd0);

    // Randomized tables, lengths and datapath corruption.
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < NUM_VEC; a++) begin
        v  = 4'($urandom);
        ex = ($urandom_range(0, 3) != 0) ? gate_fn(v) : 10'($urandom);
        writeEntry(a, v, ex, 4'($urandom_range(0, 15)));
      end
      cmask = 16'($urandom & $urandom & $urandom);
      runAndCheck($sformatf("rand%0d", it), $urandom_range(0, 15), 1'b0, 0, 0, 0, 1'b0, 0,
                  1'b0, 0, 4'd0, 10'd0, 4'd0);
    end
    cmask = '0;

    // Reset pulse in the middle of a run.
    writeEntry(0, 4'b1111, 10'h000, 4'd1);
    writeEntry(1, 4'b1001, gate_fn(4'b1001), 4'd8);
    applyStimulus(1'b0, '0, '0, '0, '0, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mid fail_seen", 32'(bus.fail_seen), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midrst pins", 32'(pins), 32'd0);
    checkOutput("midrst busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst done", 32'(bus.done), 32'd0);
    checkOutput("midrst fail_cnt", 32'(bus.fail_cnt), 32'd0);
    checkOutput("midrst fail_seen", 32'(bus.fail_seen), 32'd0);
    #3 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NUM_VEC; i++) begin
      sh_vec[i] = '0; sh_exp[i] = '0; sh_dwell[i] = '0;
    end
    runAndCheck("post_reset", 5, 1'b1, 5, 0, 0, 1'b0, 6, 1'b0, 0, 4'd0, 10'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
